prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 11: instruction-memory word-address width.
REQ-002 Parameter MAX_WORDS, default 2048: largest accepted program length in words; SHALL be at most 2^ADDR_W.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 start  in  1  one-cycle pulse; begins a load when in IDLE, DONE or ERR.
REQ-006 rx_valid  in  1  byte-stream source has a byte.
REQ-007 rx_data  in  8  stream byte.
REQ-008 rx_ready  out  1  loader accepts byte; transfer occurs when rx_valid && rx_ready on a posedge.
REQ-009 im_we  out  1  instruction-memory write strobe, one cycle per word.
REQ-010 im_addr  out  ADDR_W  word address of the write.
REQ-011 im_wdata  out  32  word to write.
REQ-012 cpu_hold  out  1  holds the CPU in reset while high.
REQ-013 busy  out  1  load in progress.
REQ-014 done  out  1  last load completed without error; sticky until next start or rst.
REQ-015 err  out  1  last load failed; sticky until next start or rst.

Function
REQ-016 States SHALL be IDLE, HDR0, HDR1, DATA, WRITE, CHK, DONE, ERR.
REQ-017 Stream format: count low byte, count high byte (16-bit word count N), then N words of 4 bytes each, least-significant byte first.
REQ-018 IDLE/DONE/ERR + start -> HDR0; the cycle after start, done=0, err=0, busy=1, cpu_hold=1, and the word counter and address are 0.
REQ-019 HDR0 accepts a byte -> HDR1; HDR1 accepts a byte -> latch N and go to DATA, or to DONE if N=0, or to ERR if N>MAX_WORDS.
REQ-020 rx_ready=1 only in HDR0, HDR1, DATA and CHK; it is 0 in all other states.
REQ-021 DATA assembles bytes into a 32-bit shift register; byte k (0..3) goes to bits [8k+7:8k]; the 4th accepted byte moves to WRITE.
REQ-022 WRITE lasts exactly one cycle: im_we=1, im_addr=word index, im_wdata=assembled word; rx_ready=0; latency from the 4th byte's posedge to im_we high is 1 cycle.
REQ-023 After WRITE, the index increments; if the index equals N, go to CHK (CHECKSUM_EN defined) or DONE; otherwise return to DATA.
REQ-024 im_addr SHALL wrap modulo 2^ADDR_W; no wrap occurs under REQ-019 limits.
REQ-025 rx_valid=0 stalls any receiving state indefinitely, with no timeout and no state change.
REQ-026 start is ignored while busy=1.
REQ-027 DONE: busy=0, cpu_hold=0, done=1. ERR: busy=0, cpu_hold=1, err=1.
REQ-028 im_we SHALL never be high outside WRITE.

Reset
REQ-029 rst SHALL, on the next posedge and regardless of state, force IDLE, and set rx_ready=0, im_we=0, im_addr=0, im_wdata=0, busy=0, done=0 and err=0.
REQ-030 cpu_hold resets to 1; the CPU stays held until the first successful load.
REQ-031 rst during a load abandons it; any words already written remain in memory and are not rolled back.

Configuration
REQ-032 Macro PROG_LOADER_CHECKSUM_EN: when defined, after the last word CHK accepts one byte; if it equals the XOR of all 4N payload bytes go to DONE, otherwise go to ERR. The header is excluded from the XOR.
REQ-033 When the macro is undefined, there is no CHK state, no checksum byte is consumed, and no checksum logic is present.

Verification
REQ-034 Reset then start, stream 02 00 | 78 56 34 12 | EF BE AD DE -> im_we pulses at addr 0 data 0x12345678 and at addr 1 data 0xDEADBEEF, then done=1 and cpu_hold=0.
REQ-035 Header 00 00 -> no im_we, done=1 two cycles after the second header byte.
REQ-036 Header with N=2049 (01 08) -> err=1, cpu_hold=1, no im_we.
REQ-037 1-word load with rx_valid toggled every other cycle -> same single write, addr 0; rx_ready=0 in the WRITE cycle.
REQ-038 rst asserted after 5 payload bytes -> next cycle IDLE, busy=0; a following start and full 1-word load writes addr 0.
REQ-039 CHECKSUM_EN defined, word 0x000000FF, checksum byte FF -> done=1; checksum byte 00 -> err=1.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time program loader: pulls a length-prefixed byte stream into instruction memory while holding the CPU.
// Optional macro PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte checked before release.
//
// state | meaning
// IDLE  | after reset, waiting for start; CPU held
// HDR0  | waiting for word-count low byte
// HDR1  | waiting for word-count high byte
// DATA  | collecting the 4 bytes of the next word
// WRITE | single-cycle instruction-memory write
// CHK   | waiting for checksum byte (checksum build only)
// DONE  | load succeeded; CPU released
// ERR   | load rejected; CPU held
module prog_loader #(
    parameter int ADDR_W    = 11,
    parameter int MAX_WORDS = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR
`ifdef PROG_LOADER_CHECKSUM_EN
        , CHK
`endif
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t      state, state_nx;
    logic [7:0]  n_lo;
    logic [15:0] n_words;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [31:0] shift;
    logic [15:0] hdr_n;
    logic        last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  chk_acc;
`endif

    assign im_addr  = ADDR_W'(word_cnt);
    assign im_wdata = shift;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        rx_ready  = 1'b0;
        im_we     = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        cpu_hold  = 1'b1;
        hdr_n     = {rx_data, n_lo};
        last_word = (word_cnt + 16'd1) == n_words;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = HDR0;
            end
            HDR0: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nx = HDR1;
            end
            HDR1: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (hdr_n == 16'd0)                state_nx = DONE;
                    else if ({1'b0, hdr_n} > MAX_N)    state_nx = ERR;
                    else                               state_nx = DATA;
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                if (rx_valid && byte_cnt == 2'd3) state_nx = WRITE;
            end
            WRITE: begin
                im_we = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                state_nx = last_word ? CHK : DATA;
`else
                state_nx = last_word ? DONE : DATA;
`endif
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nx = (rx_data == chk_acc) ? DONE : ERR;
            end
`endif
            DONE: begin
                busy     = 1'b0;
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_nx = HDR0;
            end
            ERR: begin
                busy = 1'b0;
                err  = 1'b1;
                if (start) state_nx = HDR0;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Bytes shift in from the top so byte k lands in bits [8k+7:8k] after four transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_lo     <= '0;
            n_words  <= '0;
            word_cnt <= '0;
            byte_cnt <= '0;
            shift    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_acc  <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        word_cnt <= '0;
                        byte_cnt <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        chk_acc  <= '0;
`endif
                    end
                end
                HDR0: if (rx_valid) n_lo <= rx_data;
                HDR1: if (rx_valid) n_words <= {rx_data, n_lo};
                DATA: begin
                    if (rx_valid) begin
                        shift    <= {rx_data, shift[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        chk_acc  <= chk_acc ^ rx_data;
`endif
                    end
                end
                WRITE: word_cnt <= word_cnt + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed scenarios plus random loads scored against a byte-stream model.
module tb_prog_loader;

    localparam int ADDR_W    = 11;
    localparam int MAX_WORDS = 2048;

    logic              clk = 1'b0;
    logic              rst, start, rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready, im_we, cpu_hold, busy, done, err;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    int n_checks = 0;
    int n_pass   = 0;
    int we_ready_bad = 0;

    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];
    logic [31:0]       words[$];

    prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we) begin
            got_addr.push_back(im_addr);
            got_data.push_back(im_wdata);
            if (rx_ready) we_ready_bad++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
        int n;
        n = 0;
        if (gaps) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 50) begin
            tick();
            n++;
        end
        ok = (n < 50);
        tick();
        rx_valid = 1'b0;
        rx_data  = $urandom_range(0, 255);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        int n;
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        ok = !busy;
    endtask

    // Builds the expected stream and outcome from the words queue, runs the load, scores it.
    task automatic run_load(input string tag, input logic [15:0] n, input bit gaps,
                            input bit chk_bad, input bit poke_start);
        logic [7:0]  stream[$];
        logic [7:0]  x;
        logic [31:0] w;
        bit          exp_err, ok, all_ok;
        int          exp_writes, nbad;
        x = 8'h00;
        all_ok = 1'b1;
        nbad = 0;
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
        exp_err = (int'(n) > MAX_WORDS);
        exp_writes = exp_err ? 0 : int'(n);
        for (int i = 0; i < exp_writes; i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) begin
                stream.push_back(w[8*k +: 8]);
                x ^= w[8*k +: 8];
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (!exp_err && n != 16'd0) begin
            stream.push_back(chk_bad ? ~x : x);
            if (chk_bad) exp_err = 1'b1;
        end
`else
        if (chk_bad) x = ~x;
`endif
        got_addr.delete();
        got_data.delete();
        pulse_start();
        check({tag, "/start_busy"}, busy, 1);
        check({tag, "/start_done"}, done, 0);
        check({tag, "/start_err"}, err, 0);
        check({tag, "/start_hold"}, cpu_hold, 1);
        check({tag, "/start_addr"}, im_addr, 0);
        for (int i = 0; i < stream.size(); i++) begin
            send_byte(stream[i], gaps, ok);
            if (!ok) all_ok = 1'b0;
            if (poke_start && i == 2) pulse_start();
        end
        wait_idle(2, ok);
        if (!ok) all_ok = 1'b0;
        check({tag, "/no_timeout"}, all_ok, 1);
        check({tag, "/done"}, done, !exp_err);
        check({tag, "/err"}, err, exp_err);
        check({tag, "/hold"}, cpu_hold, exp_err);
        check({tag, "/nwrites"}, got_addr.size(), exp_writes);
        for (int i = 0; i < exp_writes && i < got_addr.size(); i++)
            if (got_addr[i] !== ADDR_W'(i) || got_data[i] !== words[i]) nbad++;
        check({tag, "/write_bad"}, nbad, 0);
    endtask

    initial begin
        bit ok;
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        tick(); tick();
        check("rst/rx_ready", rx_ready, 0);
        check("rst/im_we", im_we, 0);
        check("rst/im_addr", im_addr, 0);
        check("rst/im_wdata", im_wdata, 0);
        check("rst/busy", busy, 0);
        check("rst/done", done, 0);
        check("rst/err", err, 0);
        check("rst/hold", cpu_hold, 1);
        rst = 1'b0;
        tick();
        check("idle/hold", cpu_hold, 1);

        words.delete();
        words.push_back(32'h12345678);
        words.push_back(32'hDEADBEEF);
        run_load("two_words", 16'd2, 1'b0, 1'b0, 1'b0);

        run_load("zero_hdr", 16'd0, 1'b0, 1'b0, 1'b0);
        run_load("too_long", 16'd2049, 1'b0, 1'b0, 1'b0);

        words.delete();
        words.push_back($urandom);
        run_load("gapped_one", 16'd1, 1'b1, 1'b0, 1'b0);

        // Abandon a load partway through the second word.
        words.delete();
        words.push_back(32'hA1B2C3D4);
        words.push_back(32'h55667788);
        got_addr.delete();
        got_data.delete();
        pulse_start();
        send_byte(8'h02, 1'b0, ok);
        send_byte(8'h00, 1'b0, ok);
        send_byte(8'hD4, 1'b0, ok);
        send_byte(8'hC3, 1'b0, ok);
        send_byte(8'hB2, 1'b0, ok);
        send_byte(8'hA1, 1'b0, ok);
        send_byte(8'h88, 1'b0, ok);
        rst = 1'b1;
        tick();
        check("mid_rst/busy", busy, 0);
        check("mid_rst/rx_ready", rx_ready, 0);
        check("mid_rst/im_we", im_we, 0);
        check("mid_rst/done", done, 0);
        check("mid_rst/err", err, 0);
        check("mid_rst/hold", cpu_hold, 1);
        check("mid_rst/im_addr", im_addr, 0);
        rst = 1'b0;
        tick();
        check("mid_rst/kept_write", got_addr.size(), 1);
        words.delete();
        words.push_back(32'h0BADF00D);
        run_load("after_rst", 16'd1, 1'b0, 1'b0, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
        words.delete();
        words.push_back(32'h000000FF);
        run_load("chk_good", 16'd1, 1'b0, 1'b0, 1'b0);
        run_load("chk_bad", 16'd1, 1'b0, 1'b1, 1'b0);
`endif

        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(1, 6);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            run_load($sformatf("rand%0d", r), 16'(n), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), r == 3);
        end

        words.delete();
        for (int i = 0; i < MAX_WORDS; i++) words.push_back($urandom);
        run_load("max_len", 16'(MAX_WORDS), 1'b0, 1'b0, 1'b0);

        check("we_without_ready", we_ready_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
